sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Two-client arbiter sitting directly upstream of the SRAM controller.
//  Merges client 0 (image ingest / write-heavy) and client 1 (SIFT pipeline
//  / read-heavy) onto the single SRAM request port, round-robin.
//  Routes in-order read returns back to the issuing client via a tag FIFO.
//  Controller contract: ready always 1; write_mask==0 means read.
// PARAMETERS
//  ADDR_W    18  SRAM word address width
//  DATA_W    32  SRAM data width
//  TAG_DEPTH 8   read tag FIFO depth (power of 2); caps outstanding reads
// PORTS
//  clock          in   1       single clock; all logic on posedge
//  reset          in   1       synchronous, active-high
//  cN_valid       in   1       client N (N=0,1) request valid
//  cN_ready       out  1       client N request accepted this cycle
//  cN_we          in   1       1=write, 0=read
//  cN_addr        in   ADDR_W  word address
//  cN_wdata       in   DATA_W  write data
//  cN_wmask       in   4       byte enables (writes only)
//  cN_rvalid      out  1       read data for client N valid
//  rdata          out  DATA_W  shared read data (qualified by cN_rvalid)
//  sram_addr_valid out 1       to controller addr_valid
//  sram_addr      out  ADDR_W  to controller addr
//  sram_data_in   out  DATA_W  to controller data_in
//  sram_write_mask out 4       to controller write_mask
//  sram_data_out  in   DATA_W  from controller data_out
//  sram_data_out_valid in 1    from controller data_out_valid
//  tag_error      out  1       sticky: return with empty tag FIFO
// BEHAVIOUR
//  Reset: all outputs 0 (cN_ready, cN_rvalid, sram_addr_valid, sram_addr,
//   sram_data_in, sram_write_mask, tag_error); tag FIFO empty; last_grant=1.
//  Eligibility: client eligible if cN_valid && (cN_we || !tag_full).
//  Arbitration (comb): one eligible -> grant it; both -> grant !last_grant;
//   last_grant updates only on an actual grant. cN_ready = grant_N.
//  Handshake: accept on cN_valid&&cN_ready; client holds fields stable until
//   accepted; valid may drop without acceptance.
//  Issue: accepted request registered to sram_* next cycle (1-cycle latency).
//   Read -> sram_write_mask=4'h0. Write -> sram_write_mask=cN_wmask.
//   Write with cN_wmask==0: accepted, dropped, sram_addr_valid stays 0.
//   No grant -> sram_addr_valid=0, sram_write_mask=0 (other fields hold).
//  Tag FIFO: push client ID on accepted read; pop on sram_data_out_valid.
//   Push+pop same cycle legal incl. when full; count unchanged.
//   tag_full blocks further reads only; writes still flow.
//  Return: cN_rvalid = sram_data_out_valid && head_tag==N (comb);
//   rdata = sram_data_out passthrough. Read accepted at T -> cN_rvalid at T+5.
//  Error: sram_data_out_valid with FIFO empty -> no rvalid, tag_error<=1
//   sticky until reset.
//  Reset mid-operation: FIFO flushed; in-flight returns after reset raise
//   tag_error (controller must be reset together).
// TESTING
//  Reset -> all outputs 0; first cycle both valid -> c0 granted.
//  c0,c1 both hold reads 6 cycles -> grants alternate 0,1,0,1,0,1; rvalid
//   order identical, each 5 cycles after accept, rdata matches model.
//  c1 issues 8 reads, SRAM model stalled -> 9th read ready=0 while c0 writes
//   still accepted; first return frees slot same cycle.
//  c0 write addr 0x3FFFF data 0xDEADBEEF mask 0x5 -> next cycle sram_addr
//   0x3FFFF, write_mask 0x5; mask 0x0 write -> no sram_addr_valid.
//  Inject sram_data_out_valid with empty FIFO -> no cN_rvalid, tag_error=1
//   stays 1 until reset.
//  Reset asserted with 3 reads outstanding -> FIFO empty, outputs 0.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-client round-robin arbiter in front of the SRAM controller.
// Read returns are steered back to their issuer by an in-order tag FIFO.
module sram_arbiter #(
   parameter int unsigned ADDR_W    = 18,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned TAG_DEPTH = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              c0_valid,
   output logic              c0_ready,
   input  logic              c0_we,
   input  logic [ADDR_W-1:0] c0_addr,
   input  logic [DATA_W-1:0] c0_wdata,
   input  logic [3:0]        c0_wmask,
   output logic              c0_rvalid,
   input  logic              c1_valid,
   output logic              c1_ready,
   input  logic              c1_we,
   input  logic [ADDR_W-1:0] c1_addr,
   input  logic [DATA_W-1:0] c1_wdata,
   input  logic [3:0]        c1_wmask,
   output logic              c1_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              sram_addr_valid,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_data_in,
   output logic [3:0]        sram_write_mask,
   input  logic [DATA_W-1:0] sram_data_out,
   input  logic              sram_data_out_valid,
   output logic              tag_error
);

   localparam int unsigned PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic                 last_grant_q, last_grant_d;
   logic [TAG_DEPTH-1:0] tag_mem_q, tag_mem_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 sram_addr_valid_q, sram_addr_valid_d;
   logic [ADDR_W-1:0]    sram_addr_q, sram_addr_d;
   logic [DATA_W-1:0]    sram_data_in_q, sram_data_in_d;
   logic [3:0]           sram_write_mask_q, sram_write_mask_d;
   logic                 tag_error_q, tag_error_d;

   logic                 pop_c, push_c, tag_full_c, head_tag_c;
   logic                 elig0_c, elig1_c, grant0_c, grant1_c, gnt_id_c;
   logic                 gnt_we_c;
   logic [ADDR_W-1:0]    gnt_addr_c;
   logic [DATA_W-1:0]    gnt_wdata_c;
   logic [3:0]           gnt_wmask_c;

   // Arbitration, issue formatting and tag FIFO bookkeeping
   always_comb begin
      last_grant_d      = last_grant_q;
      tag_mem_d         = tag_mem_q;
      wr_ptr_d          = wr_ptr_q;
      rd_ptr_d          = rd_ptr_q;
      sram_addr_valid_d = 1'b0;
      sram_addr_d       = sram_addr_q;
      sram_data_in_d    = sram_data_in_q;
      sram_write_mask_d = 4'h0;
      grant0_c          = 1'b0;
      grant1_c          = 1'b0;

      // A return in this cycle frees its slot for a read accepted alongside it
      pop_c      = sram_data_out_valid && (count_q != '0);
      tag_full_c = (count_q == CNT_W'(TAG_DEPTH)) && !pop_c;
      elig0_c    = c0_valid && (c0_we || !tag_full_c);
      elig1_c    = c1_valid && (c1_we || !tag_full_c);

      if (!reset) begin
         if (elig0_c && elig1_c) begin
            grant0_c = last_grant_q;
            grant1_c = !last_grant_q;
         end else begin
            grant0_c = elig0_c;
            grant1_c = elig1_c;
         end
      end

      gnt_id_c    = grant1_c;
      gnt_we_c    = gnt_id_c ? c1_we    : c0_we;
      gnt_addr_c  = gnt_id_c ? c1_addr  : c0_addr;
      gnt_wdata_c = gnt_id_c ? c1_wdata : c0_wdata;
      gnt_wmask_c = gnt_id_c ? c1_wmask : c0_wmask;
      push_c      = (grant0_c || grant1_c) && !gnt_we_c;
      head_tag_c  = tag_mem_q[rd_ptr_q];

      if (grant0_c || grant1_c) begin
         last_grant_d   = gnt_id_c;
         sram_addr_d    = gnt_addr_c;
         sram_data_in_d = gnt_wdata_c;
         if (!gnt_we_c) begin
            sram_addr_valid_d = 1'b1;
         end else if (gnt_wmask_c != 4'h0) begin
            sram_addr_valid_d = 1'b1;
            sram_write_mask_d = gnt_wmask_c;
         end
      end

      if (push_c) begin
         tag_mem_d[wr_ptr_q] = gnt_id_c;
         wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d     = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      tag_error_d = tag_error_q | (sram_data_out_valid && (count_q == '0));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         last_grant_q      <= 1'b1;
         tag_mem_q         <= '0;
         wr_ptr_q          <= '0;
         rd_ptr_q          <= '0;
         count_q           <= '0;
         sram_addr_valid_q <= 1'b0;
         sram_addr_q       <= '0;
         sram_data_in_q    <= '0;
         sram_write_mask_q <= 4'h0;
         tag_error_q       <= 1'b0;
      end else begin
         last_grant_q      <= last_grant_d;
         tag_mem_q         <= tag_mem_d;
         wr_ptr_q          <= wr_ptr_d;
         rd_ptr_q          <= rd_ptr_d;
         count_q           <= count_d;
         sram_addr_valid_q <= sram_addr_valid_d;
         sram_addr_q       <= sram_addr_d;
         sram_data_in_q    <= sram_data_in_d;
         sram_write_mask_q <= sram_write_mask_d;
         tag_error_q       <= tag_error_d;
      end
   end

   assign c0_ready        = grant0_c;
   assign c1_ready        = grant1_c;
   assign c0_rvalid       = pop_c && !head_tag_c && !reset;
   assign c1_rvalid       = pop_c &&  head_tag_c && !reset;
   assign rdata           = sram_data_out;
   assign sram_addr_valid = sram_addr_valid_q;
   assign sram_addr       = sram_addr_q;
   assign sram_data_in    = sram_data_in_q;
   assign sram_write_mask = sram_write_mask_q;
   assign tag_error       = tag_error_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM controller model, queue-based scoreboard
// checked every cycle, and directed scenarios with literal expectations.
module tb_sram_arbiter;

   localparam int unsigned ADDR_W    = 18;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned TAG_DEPTH = 8;

   logic              clock = 1'b0;
   logic              reset;
   logic              c0_valid, c0_ready, c0_we, c0_rvalid;
   logic [ADDR_W-1:0] c0_addr;
   logic [DATA_W-1:0] c0_wdata;
   logic [3:0]        c0_wmask;
   logic              c1_valid, c1_ready, c1_we, c1_rvalid;
   logic [ADDR_W-1:0] c1_addr;
   logic [DATA_W-1:0] c1_wdata;
   logic [3:0]        c1_wmask;
   logic [DATA_W-1:0] rdata;
   logic              sram_addr_valid;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_data_in;
   logic [3:0]        sram_write_mask;
   logic [DATA_W-1:0] sram_data_out;
   logic              sram_data_out_valid;
   logic              tag_error;

   sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)) dut (
      .clock(clock), .reset(reset),
      .c0_valid(c0_valid), .c0_ready(c0_ready), .c0_we(c0_we), .c0_addr(c0_addr),
      .c0_wdata(c0_wdata), .c0_wmask(c0_wmask), .c0_rvalid(c0_rvalid),
      .c1_valid(c1_valid), .c1_ready(c1_ready), .c1_we(c1_we), .c1_addr(c1_addr),
      .c1_wdata(c1_wdata), .c1_wmask(c1_wmask), .c1_rvalid(c1_rvalid),
      .rdata(rdata),
      .sram_addr_valid(sram_addr_valid), .sram_addr(sram_addr),
      .sram_data_in(sram_data_in), .sram_write_mask(sram_write_mask),
      .sram_data_out(sram_data_out), .sram_data_out_valid(sram_data_out_valid),
      .tag_error(tag_error)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pattern(input logic [ADDR_W-1:0] a);
      return 32'hA500_0000 ^ {14'd0, a};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   // SRAM controller model: read data 4 cycles after addr_valid, optional stall
   typedef struct { logic [31:0] data; int due; } pend_t;
   pend_t       pend[$];
   logic [31:0] mem [logic [ADDR_W-1:0]];
   logic        stall = 1'b0;
   logic        inject = 1'b0;
   int          scyc = 0;

   function automatic logic [31:0] mem_rd(input logic [ADDR_W-1:0] a);
      return mem.exists(a) ? mem[a] : pattern(a);
   endfunction

   initial begin
      sram_data_out_valid = 1'b0;
      sram_data_out       = '0;
      forever begin
         @(posedge clock);
         #2;
         scyc++;
         sram_data_out_valid = 1'b0;
         if (reset) begin
            pend.delete();
         end else begin
            if (sram_addr_valid) begin
               if (sram_write_mask == 4'h0)
                  pend.push_back('{data: mem_rd(sram_addr), due: scyc + 4});
               else
                  mem[sram_addr] = merge(mem_rd(sram_addr), sram_data_in, sram_write_mask);
            end
            if (inject) begin
               sram_data_out_valid = 1'b1;
               sram_data_out       = $urandom;
            end else if (!stall && pend.size() > 0 && pend[0].due <= scyc) begin
               sram_data_out_valid = 1'b1;
               sram_data_out       = pend[0].data;
               void'(pend.pop_front());
            end
         end
      end
   end

   // Scoreboard: expected outputs derived from the arbitration/return rules
   typedef struct { logic id; logic [31:0] data; int acc; } tag_t;
   tag_t        tq[$];
   logic [31:0] shadow [logic [ADDR_W-1:0]];
   logic        exp_av = 1'b0, exp_err = 1'b0, fresh = 1'b0, last_m = 1'b1;
   logic [3:0]  exp_wm = 4'h0;
   logic [ADDR_W-1:0] exp_addr = '0;
   logic [DATA_W-1:0] exp_din = '0;
   logic        chk_lat = 1'b0;
   int          ncyc = 0, rv0_cnt = 0, rv1_cnt = 0;

   function automatic logic [31:0] sh_rd(input logic [ADDR_W-1:0] a);
      return shadow.exists(a) ? shadow[a] : pattern(a);
   endfunction

   always @(negedge clock) begin
      logic pop_m, full_m, e0, e1, g0, g1, gid, gwe;
      logic [ADDR_W-1:0] ga;
      logic [DATA_W-1:0] gd;
      logic [3:0] gm;
      ncyc++;
      chk("sram_addr_valid", 32'(sram_addr_valid), 32'(exp_av));
      chk("sram_write_mask", 32'(sram_write_mask), 32'(exp_wm));
      chk("tag_error", 32'(tag_error), 32'(exp_err));
      if (exp_av || fresh) chk("sram_addr", 32'(sram_addr), 32'(exp_addr));
      if ((exp_av && exp_wm != 4'h0) || fresh) chk("sram_data_in", sram_data_in, exp_din);
      fresh = 1'b0;
      if (reset) begin
         chk("ready_in_reset", {30'd0, c1_ready, c0_ready}, 32'd0);
         chk("rvalid_in_reset", {30'd0, c1_rvalid, c0_rvalid}, 32'd0);
         tq.delete();
         exp_av = 1'b0; exp_wm = 4'h0; exp_addr = '0; exp_din = '0;
         exp_err = 1'b0; last_m = 1'b1; fresh = 1'b1;
      end else begin
         rv0_cnt += int'(c0_rvalid);
         rv1_cnt += int'(c1_rvalid);
         pop_m  = sram_data_out_valid && tq.size() > 0;
         full_m = (tq.size() == TAG_DEPTH) && !pop_m;
         e0 = c0_valid && (c0_we || !full_m);
         e1 = c1_valid && (c1_we || !full_m);
         if (e0 && e1) begin g0 = last_m; g1 = !last_m; end
         else begin g0 = e0; g1 = e1; end
         chk("c0_ready", 32'(c0_ready), 32'(g0));
         chk("c1_ready", 32'(c1_ready), 32'(g1));
         chk("c0_rvalid", 32'(c0_rvalid), 32'(pop_m && tq[0].id == 1'b0));
         chk("c1_rvalid", 32'(c1_rvalid), 32'(pop_m && tq[0].id == 1'b1));
         if (pop_m) begin
            chk("rdata", rdata, tq[0].data);
            if (chk_lat) chk("read_latency", 32'(ncyc - tq[0].acc), 32'd5);
            void'(tq.pop_front());
         end else if (sram_data_out_valid) begin
            exp_err = 1'b1;
         end
         exp_av = 1'b0;
         exp_wm = 4'h0;
         if (g0 || g1) begin
            gid = g1;
            gwe = gid ? c1_we : c0_we;
            ga  = gid ? c1_addr : c0_addr;
            gd  = gid ? c1_wdata : c0_wdata;
            gm  = gid ? c1_wmask : c0_wmask;
            last_m = gid;
            if (!gwe) begin
               tq.push_back('{id: gid, data: sh_rd(ga), acc: ncyc});
               exp_av = 1'b1; exp_addr = ga;
            end else if (gm != 4'h0) begin
               shadow[ga] = merge(sh_rd(ga), gd, gm);
               exp_av = 1'b1; exp_wm = gm; exp_addr = ga; exp_din = gd;
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   int          exp_g[6] = '{0, 1, 0, 1, 0, 1};
   int          g, i0, i1;
   logic        seen;
   logic [31:0] got;

   initial begin
      reset = 1'b1;
      c0_valid = 1'b0; c0_we = 1'b0; c0_addr = '0; c0_wdata = '0; c0_wmask = 4'h0;
      c1_valid = 1'b0; c1_we = 1'b0; c1_addr = '0; c1_wdata = '0; c1_wmask = 4'h0;
      next_cycle();
      next_cycle();
      reset = 1'b0;
      @(negedge clock);
      chk("reset_outputs", {25'd0, sram_addr_valid, sram_write_mask, tag_error,
                            c0_ready, c1_ready}, 32'd0);
      chk("reset_addr", 32'(sram_addr), 32'd0);
      chk("reset_data_in", sram_data_in, 32'd0);
      next_cycle();

      // Both clients hold reads: grants alternate starting with client 0
      chk_lat = 1'b1;
      i0 = 0; i1 = 0;
      for (int k = 0; k < 6; k++) begin
         c0_valid = 1'b1; c0_we = 1'b0; c0_addr = ADDR_W'(32'h100 + 32'(i0));
         c1_valid = 1'b1; c1_we = 1'b0; c1_addr = ADDR_W'(32'h200 + 32'(i1));
         @(negedge clock);
         g = c0_ready ? 0 : (c1_ready ? 1 : 9);
         chk($sformatf("grant_seq%0d", k), 32'(g), 32'(exp_g[k]));
         if (c0_ready) i0++;
         if (c1_ready) i1++;
         next_cycle();
      end
      c0_valid = 1'b0; c1_valid = 1'b0;
      repeat (8) next_cycle();
      chk("rv0_count", 32'(rv0_cnt), 32'd3);
      chk("rv1_count", 32'(rv1_cnt), 32'd3);
      chk_lat = 1'b0;

      // Boundary address write, then a zero-mask write that must be dropped
      c0_valid = 1'b1; c0_we = 1'b1; c0_addr = 18'h3FFFF; c0_wdata = 32'hDEADBEEF; c0_wmask = 4'h5;
      @(negedge clock);
      chk("wr_ready", 32'(c0_ready), 32'd1);
      next_cycle();
      c0_addr = 18'h3FFFF; c0_wdata = 32'h12345678; c0_wmask = 4'h0;
      @(negedge clock);
      chk("wr_addr_valid", 32'(sram_addr_valid), 32'd1);
      chk("wr_addr", 32'(sram_addr), 32'h3FFFF);
      chk("wr_mask", 32'(sram_write_mask), 32'h5);
      chk("wr_data", sram_data_in, 32'hDEADBEEF);
      chk("wr0_ready", 32'(c0_ready), 32'd1);
      next_cycle();
      c0_valid = 1'b0;
      @(negedge clock);
      chk("wr0_dropped", 32'(sram_addr_valid), 32'd0);
      next_cycle();
      c1_valid = 1'b1; c1_we = 1'b0; c1_addr = 18'h3FFFF;
      @(negedge clock);
      next_cycle();
      c1_valid = 1'b0;
      seen = 1'b0; got = '0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         if (c1_rvalid && !seen) begin seen = 1'b1; got = rdata; end
         next_cycle();
      end
      chk("readback_seen", 32'(seen), 32'd1);
      chk("readback_data", got, 32'hA5ADFFEF);

      // Stalled controller: 8 reads fill the tag FIFO, writes still flow
      stall = 1'b1;
      for (int k = 0; k < 8; k++) begin
         c1_valid = 1'b1; c1_we = 1'b0; c1_addr = ADDR_W'(32'h300 + 32'(k));
         @(negedge clock);
         next_cycle();
      end
      c1_addr = 18'h308;
      for (int k = 0; k < 3; k++) begin
         c0_valid = 1'b1; c0_we = 1'b1; c0_addr = ADDR_W'(32'h400 + 32'(k));
         c0_wdata = 32'(k); c0_wmask = 4'hF;
         @(negedge clock);
         chk("full_read_blocked", 32'(c1_ready), 32'd0);
         chk("full_write_flows", 32'(c0_ready), 32'd1);
         next_cycle();
      end
      c0_valid = 1'b0;
      @(negedge clock);
      chk("full_read_blocked_idle", 32'(c1_ready), 32'd0);
      next_cycle();
      stall = 1'b0;
      @(negedge clock);
      chk("slot_freed_ready", 32'(c1_ready), 32'd1);
      chk("slot_freed_rvalid", 32'(c1_rvalid), 32'd1);
      next_cycle();
      c1_valid = 1'b0;
      repeat (14) next_cycle();

      // Return with empty FIFO: no rvalid, sticky tag_error
      inject = 1'b1;
      @(negedge clock);
      chk("orphan_rvalid", {30'd0, c1_rvalid, c0_rvalid}, 32'd0);
      next_cycle();
      inject = 1'b0;
      @(negedge clock);
      chk("tag_error_set", 32'(tag_error), 32'd1);
      repeat (3) next_cycle();
      @(negedge clock);
      chk("tag_error_sticky", 32'(tag_error), 32'd1);
      next_cycle();

      // Reset with three reads outstanding
      for (int k = 0; k < 3; k++) begin
         c0_valid = 1'b1; c0_we = 1'b0; c0_addr = ADDR_W'(32'h500 + 32'(k));
         next_cycle();
      end
      c0_valid = 1'b0;
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      @(negedge clock);
      chk("midreset_outputs", {25'd0, sram_addr_valid, sram_write_mask, tag_error,
                               c0_rvalid, c1_rvalid}, 32'd0);
      chk("midreset_addr", 32'(sram_addr), 32'd0);
      chk("midreset_data_in", sram_data_in, 32'd0);
      repeat (8) next_cycle();
      @(negedge clock);
      chk("midreset_no_error", 32'(tag_error), 32'd0);
      next_cycle();
      inject = 1'b1;
      @(negedge clock);
      chk("midreset_fifo_empty_rvalid", {30'd0, c1_rvalid, c0_rvalid}, 32'd0);
      next_cycle();
      inject = 1'b0;
      @(negedge clock);
      chk("midreset_fifo_empty_err", 32'(tag_error), 32'd1);
      next_cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
